// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request, issue and register-file write bundle
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    logic            req0_valid;
    logic [4:0]      req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [4:0]      req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            flush;
    logic            writeEnable;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic [NREG-1:0] busy_mask;

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output iss_valid, iss_rd, flush,
        input  req0_ready, req1_ready, writeEnable, write_reg, write_data, busy_mask
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  iss_valid, iss_rd, flush,
        output req0_ready, req1_ready, writeEnable, write_reg, write_data, busy_mask
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin register-file write-port arbiter with busy scoreboard
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic clk,
    input logic rst,
    rf_wb_arbiter_if.slave bus
);
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

    pri_t            pri, pri_next;
    logic            grant0, grant1, ready0, ready1, xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] busy, busy_next;
    logic            we;
    logic [4:0]      wreg;
    logic [XLEN-1:0] wdata;

    // Grant the lone requester, or the one named by priority; flush and reset block the handshake
    always_comb begin
        grant0   = bus.req0_valid & (~bus.req1_valid | (pri == PRI0));
        grant1   = bus.req1_valid & (~bus.req0_valid | (pri == PRI1));
        ready0   = grant0 & ~bus.flush & ~rst;
        ready1   = grant1 & ~bus.flush & ~rst;
        xfer     = ready0 | ready1;
        sel_rd   = ready0 ? bus.req0_rd : bus.req1_rd;
        sel_data = ready0 ? bus.req0_data : bus.req1_data;
        pri_next = ready0 ? PRI1 : (ready1 ? PRI0 : pri);
    end

    // Scoreboard: writes clear, issues set (set wins), flush clears all, x0 never busy
    always_comb begin
        busy_next = busy;
        if (xfer && sel_rd != 5'd0) busy_next[sel_rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 5'd0) busy_next[bus.iss_rd] = 1'b1;
        if (bus.flush) busy_next = '0;
        busy_next[0] = 1'b0;
    end

    // Priority state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pri <= PRI0;
        else     pri <= pri_next;
    end

    // Registered write port and busy mask; x0 transfers load the port but do not strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            wreg  <= '0;
            wdata <= '0;
            busy  <= '0;
        end else begin
            we   <= xfer & (sel_rd != 5'd0);
            busy <= busy_next;
            if (xfer) begin
                wreg  <= sel_rd;
                wdata <= sel_data;
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.writeEnable = we;
    assign bus.write_reg   = wreg;
    assign bus.write_data  = wdata;
    assign bus.busy_mask   = busy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenario tests for the writeback arbiter
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;

    rf_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();
    rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req0_rd    = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = '0;
        bus.req1_data  = '0;
        bus.iss_valid  = 1'b0;
        bus.iss_rd     = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.req0_valid = 1'b1;
        #1;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL reset_ready: r0=%b r1=%b expected 0 0", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_rd    = 5'd3;
        bus.req0_data  = 32'h11;
        bus.iss_valid  = 1'b1;
        bus.iss_rd     = 5'd9;
        @(posedge clk);
        #1;
        total++;
        if (bus.writeEnable !== 1'b1 || bus.busy_mask !== 32'h200)
            $display("FAIL pre_reset_state: we=%b busy=%h expected 1 00000200", bus.writeEnable, bus.busy_mask);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if (bus.writeEnable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'h0 || bus.busy_mask !== 32'h0)
            $display("FAIL async_reset_outputs: we=%b reg=%0d data=%h busy=%h expected all 0",
                     bus.writeEnable, bus.write_reg, bus.write_data, bus.busy_mask);
        else pass_cnt++;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL reset_mid_ready: r0=%b r1=%b expected 0 0", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bus.iss_valid  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd8;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL reset_first_grant: r0=%b r1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1)
            $display("FAIL single_ready: got %b expected 1", bus.req0_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (bus.writeEnable !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEADBEEF)
            $display("FAIL single_write: we=%b reg=%0d data=%h expected 1 5 deadbeef",
                     bus.writeEnable, bus.write_reg, bus.write_data);
        else pass_cnt++;
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        total++;
        if (bus.writeEnable !== 1'b0 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEADBEEF)
            $display("FAIL single_after: we=%b reg=%0d data=%h expected 0 5 deadbeef",
                     bus.writeEnable, bus.write_reg, bus.write_data);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        int        i0 = 0;
        int        i1 = 0;
        logic [4:0] exp_rd [4] = '{5'd1, 5'd11, 5'd2, 5'd12};
        int        exp_g  [4] = '{0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req0_valid = 1'b1;
            bus.req0_rd    = 5'(1 + i0);
            bus.req0_data  = 32'h100 + 32'(1 + i0);
            bus.req1_valid = 1'b1;
            bus.req1_rd    = 5'(11 + i1);
            bus.req1_data  = 32'h100 + 32'(11 + i1);
            #1;
            total++;
            if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || (bus.req1_ready ? 1 : 0) != exp_g[k])
                $display("FAIL contention_grant%0d: r0=%b r1=%b expected grant to req%0d",
                         k, bus.req0_ready, bus.req1_ready, exp_g[k]);
            else pass_cnt++;
            if (bus.req0_ready === 1'b1) i0++;
            if (bus.req1_ready === 1'b1) i1++;
            @(posedge clk);
            #1;
            total++;
            if (bus.writeEnable !== 1'b1 || bus.write_reg !== exp_rd[k] || bus.write_data !== 32'h100 + 32'(exp_rd[k]))
                $display("FAIL contention_write%0d: we=%b reg=%0d data=%h expected 1 %0d %h",
                         k, bus.writeEnable, bus.write_reg, bus.write_data, exp_rd[k], 32'h100 + 32'(exp_rd[k]));
            else pass_cnt++;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd2;
        bus.req0_data  = 32'h22;
        @(negedge clk);
        idle();
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd0;
        bus.req1_data  = 32'h55;
        bus.iss_valid  = 1'b1;
        bus.iss_rd     = 5'd0;
        #1;
        total++;
        if (bus.req1_ready !== 1'b1)
            $display("FAIL x0_ready: got %b expected 1", bus.req1_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (bus.writeEnable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'h55 || bus.busy_mask[0] !== 1'b0)
            $display("FAIL x0_write: we=%b reg=%0d data=%h busy0=%b expected 0 0 55 0",
                     bus.writeEnable, bus.write_reg, bus.write_data, bus.busy_mask[0]);
        else pass_cnt++;
        @(negedge clk);
        idle();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd6;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd16;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL x0_priority: r0=%b r1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_scoreboard();
        do_reset();
        @(negedge clk);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        #1;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL issue_no_ready: r0=%b r1=%b expected 0 0", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_mask !== 32'h80)
            $display("FAIL sb_set: busy=%h expected 00000080", bus.busy_mask);
        else pass_cnt++;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd7;
        bus.req0_data  = 32'h77;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_mask !== 32'h80 || bus.writeEnable !== 1'b1)
            $display("FAIL sb_set_wins: busy=%h we=%b expected 00000080 1", bus.busy_mask, bus.writeEnable);
        else pass_cnt++;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_mask !== 32'h0)
            $display("FAIL sb_clear: busy=%h expected 00000000", bus.busy_mask);
        else pass_cnt++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush();
        logic [4:0] regs [8] = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.iss_valid = 1'b1;
            bus.iss_rd    = regs[k];
        end
        @(negedge clk);
        bus.iss_valid  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd20;
        bus.req0_data  = 32'hAA;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_mask !== 32'h0000F0F0 || bus.writeEnable !== 1'b1)
            $display("FAIL flush_setup: busy=%h we=%b expected 0000f0f0 1", bus.busy_mask, bus.writeEnable);
        else pass_cnt++;
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req0_rd   = 5'd21;
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd3;
        #1;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.writeEnable !== 1'b1 || bus.write_reg !== 5'd20)
            $display("FAIL flush_cycle: r0=%b we=%b reg=%0d expected 0 1 20",
                     bus.req0_ready, bus.writeEnable, bus.write_reg);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_mask !== 32'h0 || bus.writeEnable !== 1'b0)
            $display("FAIL flush_clear: busy=%h we=%b expected 00000000 0", bus.busy_mask, bus.writeEnable);
        else pass_cnt++;
        @(negedge clk);
        idle();
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd21;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd22;
        #1;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1)
            $display("FAIL flush_pri_hold: r0=%b r1=%b expected 0 1", bus.req0_ready, bus.req1_ready);
        else pass_cnt++;
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_scoreboard();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32-entry register file. Two writeback producers (req0: ALU/load pipe, req1: multi-cycle unit such as mul/div) share the register file's single write port through a valid/ready handshake with round-robin fairness. The block registers the winning write onto `write_reg`/`write_data`/`writeEnable`. It also keeps a busy mask of destinations that have been issued but not yet written, which the hazard logic uses to stall.

## Interface
- `XLEN`, 32, data width of a register.
- `NREG`, 32, number of architectural registers; index width is 5 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  producer 0 has a write pending.
- `req0_rd`  in  5  producer 0 destination index.
- `req0_data`  in  XLEN  producer 0 write value.
- `req0_ready`  out  1  producer 0 write accepted this cycle.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready`: same as req0, for producer 1.
- `iss_valid`  in  1  an instruction with a register destination issues this cycle.
- `iss_rd`  in  5  destination of the issuing instruction.
- `flush`  in  1  synchronous pipeline flush.
- `writeEnable`  out  1  register-file write strobe (registered).
- `write_reg`  out  5  register-file write index (registered).
- `write_data`  out  XLEN  register-file write value (registered).
- `busy_mask`  out  NREG  bit i = 1 while register i has an outstanding write (registered).

## Operation
- **Priority state:** `PRI0` or `PRI1`. It resets to `PRI0`.
- **Grant rule:**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the priority state is granted.
  - Neither valid: no grant.
- **Priority update:** after any grant, the state moves to the other requester (`PRI0`→`PRI1` after a req0 grant, `PRI1`→`PRI0` after a req1 grant). With no grant, the state holds.
- **Ready:** `reqN_ready = grantN & ~flush & ~rst`. Ready is combinational from both valids and the priority state. At most one ready is high per cycle.
- **Handshake:** a transfer occurs when `reqN_valid & reqN_ready`. Producers hold `rd` and `data` stable while valid and not ready. A producer may not drop valid before it is accepted.
- **Commit:** on a transfer, the next edge loads `write_reg = rd` and `write_data = data`. It sets `writeEnable = 1` only if `rd != 0`; a transfer to x0 is accepted but writes nothing.
- **No transfer:** `writeEnable` is 0 the next cycle. `write_reg` and `write_data` hold their last values.
- **Scoreboard set:** `iss_valid & iss_rd != 0` sets `busy_mask[iss_rd]`.
- **Scoreboard clear:** an accepted transfer with `rd != 0` clears `busy_mask[rd]` at the same edge the write is registered.
- **Same register set and cleared in one cycle:** set wins; a new producer is outstanding.
- **`busy_mask[0]`:** always 0.
- **Flush:**
  - At the next edge `busy_mask` goes to 0; any `iss_valid` in the same cycle is ignored.
  - Both readies are forced to 0 for that cycle, and the priority state holds.
  - A write already registered on the output (`writeEnable = 1`) still completes.

## Timing
- **Reset values (asynchronous):** `writeEnable = 0`, `write_reg = 0`, `write_data = 0`, `busy_mask = 0`, priority `PRI0`. Both readies are 0 while `rst` is high.
- **Latency:** a transfer in cycle N gives `writeEnable = 1` in cycle N+1, for exactly one cycle per transfer. Register-file contents reflect the write after the edge ending cycle N+1.
- **Throughput:** one write per cycle. With both requesters continuously valid, grants alternate every cycle, so neither waits more than one cycle.
- **Scoreboard timing:** `busy_mask` updates one edge after the issue or transfer that causes the change.
- **Reset mid-operation:** in-flight grants and the registered write are discarded, and the busy mask is cleared. Producers must re-present after reset deasserts.
- **Combinational paths:**
  - Permitted: valid/flush/rst → ready.
  - Not permitted: any path from `iss_*` to ready.

## Test plan
- **Reset:** assert `rst` mid-stream with req0 valid → all outputs are 0 at once, both readies are 0, and after release the first grant follows `PRI0`.
- **Single requester:** req0 valid with rd=5, data=0xDEADBEEF for one cycle → `req0_ready = 1` the same cycle. Next cycle `writeEnable = 1`, `write_reg = 5`, `write_data = 0xDEADBEEF`; the cycle after, `writeEnable = 0`.
- **Contention:** both valid for 4 cycles, rd 1..4 on req0 and rd 11..14 on req1 → register-file write order is 1, 11, 2, 12. No cycle has both readies high.
- **x0 write:** req1 with rd=0, data=0x55 → `req1_ready = 1` and `writeEnable` stays 0. Priority still moves to `PRI0`, and `busy_mask[0]` stays 0.
- **Scoreboard:**
  - Issue rd=7 → `busy_mask = 0x80` next cycle.
  - A req0 transfer to rd=7 in the same cycle as a new issue of rd=7 → `busy_mask[7]` stays 1.
  - A later lone transfer to rd=7 → bit 7 clears.
- **Flush:**
  - Busy mask is 0x0000_F0F0 and req0 is valid when flush is asserted → `busy_mask = 0` next cycle and `req0_ready = 0` during the flush cycle.
  - The write registered the cycle before the flush still pulses `writeEnable`.
